// File: rtl/countdown_timer_pkg.sv
// Shared types, seven-segment constants and BCD helpers for the countdown timer.
package countdown_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Active-low segments, bit 6 = g ... bit 0 = a; element index = digit.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Three-digit BCD decrement with borrow; callers never pass 000.
    function automatic logic [2:0][3:0] bcd_dec(input logic [2:0][3:0] v);
        logic [2:0][3:0] r;
        logic            borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (borrow) begin
                if (v[i] == 4'd0) begin
                    r[i] = 4'd9;
                end else begin
                    r[i]   = v[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Board-side bundle (keys, switches, displays, LEDs) of the countdown timer.
interface countdown_timer_if;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [17:0] LEDR;

    modport master (output KEY, SW, input HEX0, HEX1, HEX2, LEDR);
    modport slave  (input KEY, SW, output HEX0, HEX1, HEX2, LEDR);
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; any code above 9 is blank.
module seg7_decode
    import countdown_timer_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) seg = SEG_DIGITS[digit];
    end
endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with start/pause and load keys.
// Optional COUNTDOWN_BLINK_EN blinks the 000 display while in DONE.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [17:0] LEDR
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic            rst_n;
    logic [1:0]      start_s, load_s;
    logic            start_q, load_q;
    logic            start_p, load_p;
    state_t          state;
    logic [2:0]      flags;
    logic [2:0][3:0] cnt;
    logic [2:0][3:0] sw_bcd;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            blank;
    logic [2:0][3:0] disp;
    logic [2:0][6:0] hex;
    logic            unused_bits;

    assign rst_n       = KEY[0];
    assign unused_bits = ^{KEY[3], SW[17:12]};

    // Keys idle high, so the synchronizers reset to 1 and release makes no edge.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            start_s <= 2'b11;
            load_s  <= 2'b11;
            start_q <= 1'b1;
            load_q  <= 1'b1;
        end else begin
            start_s <= {start_s[0], KEY[1]};
            load_s  <= {load_s[0], KEY[2]};
            start_q <= start_s[1];
            load_q  <= load_s[1];
        end
    end

    assign start_p = start_q & ~start_s[1];
    assign load_p  = load_q & ~load_s[1];
    assign sw_bcd  = {bcd_clamp(SW[11:8]), bcd_clamp(SW[7:4]), bcd_clamp(SW[3:0])};
    assign tick    = (state == S_RUN) && (presc == PRESC_MAX);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            flags <= 3'b000;
            cnt   <= '0;
            presc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    presc <= '0;
                    if (load_p) begin
                        cnt <= sw_bcd;
                    end else if (start_p && cnt != '0) begin
                        state <= S_RUN;
                        flags <= 3'b001;
                    end
                end
                S_RUN: begin
                    // Load is ignored here; a start coincident with the tick still pauses.
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick && cnt == 12'h001) begin
                        cnt   <= '0;
                        state <= S_DONE;
                        flags <= 3'b100;
                    end else begin
                        if (tick) cnt <= bcd_dec(cnt);
                        if (start_p) begin
                            state <= S_PAUSE;
                            flags <= 3'b010;
                        end
                    end
                end
                S_PAUSE: begin
                    if (load_p) begin
                        cnt   <= sw_bcd;
                        presc <= '0;
                        state <= S_IDLE;
                        flags <= 3'b000;
                    end else if (start_p) begin
                        state <= S_RUN;
                        flags <= 3'b001;
                    end
                end
                S_DONE: begin
                    presc <= '0;
                    if (load_p || start_p) begin
                        cnt   <= load_p ? sw_bcd : '0;
                        state <= S_IDLE;
                        flags <= 3'b000;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= 3'b000;
                end
            endcase
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam int            HALF = (TICK_DIV / 2 < 1) ? 1 : TICK_DIV / 2;
    localparam int            BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BMAX = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (state != S_DONE) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BMAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign blank = blink_ph && (state == S_DONE);
`else
    assign blank = 1'b0;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_seg
        assign disp[i] = blank ? 4'hF : cnt[i];
        seg7_decode u_seg (
            .digit (disp[i]),
            .seg   (hex[i])
        );
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign LEDR = {15'b0, flags};

endmodule
